// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the slice-serial adder.
// Holds the control FSM state encoding and the slice width.
package serial_adder_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/serial_cla_adder_if.sv
// Request/result bundle of the slice-serial adder.
// master drives requests and accepts results; slave is the adder.
interface serial_cla_adder_if #(
  parameter int WIDTH = 32
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             rvalid;
  logic             rready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output valid, a, b, sub, rready,
    input  ready, rvalid, result,
    input  carry, overflow, zero
  );

  modport slave (
    input  valid, a, b, sub, rready,
    output ready, rvalid, result,
    output carry, overflow, zero
  );

endinterface

// File: rtl/cla_four_fulladder.sv
// 4-bit carry-lookahead adder.
// All carries are formed from generate/propagate terms in parallel.
module cla_four_fulladder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Lookahead carries and per-bit sums.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c[3:0];
    c_o  = c[4];
  end

endmodule

// File: rtl/serial_cla_adder.sv
// Slice-serial adder/subtractor: one 4-bit CLA slice per cycle.
// IDLE accepts operands, BUSY walks the slices, DONE holds the result.
module serial_cla_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = serial_adder_pkg::SLICE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  import serial_adder_pkg::*;

  localparam int NS = WIDTH / SLICE;
  localparam int KW = $clog2(NS);
  localparam logic [KW-1:0] KLAST = KW'(NS - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cy_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q, ovf_q, zero_q;

  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             co_sl;
  logic             c_msb;
  logic [WIDTH-1:0] res_d;
  logic             last;

  // Select the current slice and merge its sum into the result.
  always_comb begin
    a_sl  = a_q[k_q*SLICE +: SLICE];
    b_sl  = b_q[k_q*SLICE +: SLICE];
    res_d = res_q;
    res_d[k_q*SLICE +: SLICE] = s_sl;
    c_msb = a_sl[SLICE-1] ^ b_sl[SLICE-1]
          ^ s_sl[SLICE-1];
    last  = (k_q == KLAST);
  end

  cla_four_fulladder u_cla (
    .a_i (a_sl),
    .b_i (b_sl),
    .c_i (cy_q),
    .s_o (s_sl),
    .c_o (co_sl)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (valid_i) state_d = BUSY;
      BUSY: if (last)    state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Operand capture, slice walk and flag update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (valid_i) begin
        a_q  <= a_i;
        b_q  <= b_i ^ {WIDTH{sub_i}};
        cy_q <= sub_i;
        k_q  <= '0;
      end
    end else if (state_q == BUSY) begin
      res_q <= res_d;
      cy_q  <= co_sl;
      k_q   <= k_q + 1'b1;
      if (last) begin
        carry_q <= co_sl;
        ovf_q   <= c_msb ^ co_sl;
        zero_q  <= ~|res_d;
      end
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = (state_q == DONE);
  assign result_o   = res_q;
  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Directed and random checks for serial_cla_adder.
// Expected values are hand-computed or from a bench-side model.
module tb_serial_cla_adder;

  logic clk;
  logic rst_i;
  int   n_chk;
  int   n_err;

  serial_cla_adder_if #(.WIDTH(32)) bus ();

  serial_cla_adder #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (bus.valid),
    .ready_o    (bus.ready),
    .a_i        (bus.a),
    .b_i        (bus.b),
    .sub_i      (bus.sub),
    .valid_o    (bus.rvalid),
    .ready_i    (bus.rready),
    .result_o   (bus.result),
    .carry_o    (bus.carry),
    .overflow_o (bus.overflow),
    .zero_o     (bus.zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s,
    input logic [31:0] er,
    input logic        ec,
    input logic        ev,
    input logic        ez,
    input int          stall
  );
    int n;
    @(negedge clk);
    chk("ready_idle", bus.ready, 1);
    bus.a      = a;
    bus.b      = b;
    bus.sub    = s;
    bus.valid  = 1'b1;
    bus.rready = 1'b0;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.a     = ~a;
    bus.b     = $urandom;
    bus.sub   = ~s;
    chk("ready_busy", bus.ready, 0);
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 8);
    chk("result", bus.result, er);
    chk("carry", bus.carry, ec);
    chk("overflow", bus.overflow, ev);
    chk("zero", bus.zero, ez);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", bus.rvalid, 1);
      chk("hold_result", bus.result, er);
    end
    @(negedge clk);
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    chk("back_ready", bus.ready, 1);
    chk("back_valid", bus.rvalid, 0);
    chk("idle_result", bus.result, er);
  endtask

  task automatic rnd_op(input int stall);
    logic [31:0] a, b, bb, r;
    logic        s, c, v;
    logic [32:0] t;
    a  = $urandom;
    b  = $urandom;
    s  = 1'($urandom_range(0, 1));
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    r  = t[31:0];
    c  = t[32];
    v  = (a[31] == bb[31]) && (r[31] != a[31]);
    op(a, b, s, r, c, v, (r == 32'd0), stall);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_i      = 1'b1;
    bus.valid  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.sub    = 1'b0;
    bus.rready = 1'b0;
    #2;
    chk("rst_ready", bus.ready, 1);
    chk("rst_valid", bus.rvalid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_zero", bus.zero, 0);
    @(negedge clk);
    rst_i = 1'b0;

    op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0,
       32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
       32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
    op(32'h0000_0005, 32'h0000_0007, 1'b1,
       32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
    op(32'h0000_0007, 32'h0000_0005, 1'b1,
       32'h0000_0002, 1'b1, 1'b0, 1'b0, 0);
    op(32'h8000_0000, 32'h0000_0001, 1'b1,
       32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
    op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0,
       32'h1010_1010, 1'b0, 1'b0, 1'b0, 5);

    // Reset in the middle of BUSY, slice 3.
    @(negedge clk);
    bus.a     = 32'hAAAA_AAAA;
    bus.b     = 32'h5555_5555;
    bus.sub   = 1'b0;
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_valid", bus.rvalid, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_carry", bus.carry, 0);
    chk("mid_rst_zero", bus.zero, 0);
    @(negedge clk);
    rst_i = 1'b0;
    op(32'h1234_5678, 32'h1111_1111, 1'b0,
       32'h2345_6789, 1'b0, 1'b0, 1'b0, 1);

    for (int i = 0; i < 300; i++)
      rnd_op($urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
